quant_out_pack: RTL
===================

Name: quant_out_pack

Overview:
Downstream of the 8-channel int8 requantiser. Each valid beat carries 8 int8 channel bytes (64 bits). The block packs every two consecutive beats into one 128-bit word and buffers the words in a show-ahead FIFO. It drives a valid/ready stream toward the feature-map DDR writer and flags the last word of each frame. The upstream quantiser has no backpressure, so the FIFO absorbs stalls and overrun is reported, never stalled.

Parameters:
DEPTH, 16, FIFO depth in 128-bit words; power of two, minimum 4
CNT_W, 16, width of the frame beat counter

Ports:
sclk  input  1  system clock
s_rst_n  input  1  asynchronous active-low reset
ch0_data_in  input  8  channel 0 int8 result
ch1_data_in  input  8  channel 1 int8 result
ch2_data_in  input  8  channel 2
ch3_data_in  input  8  channel 3
ch4_data_in  input  8  channel 4
ch5_data_in  input  8  channel 5
ch6_data_in  input  8  channel 6
ch7_data_in  input  8  channel 7
data_in_vld  input  1  beat strobe, aligned with channel data
frame_start  input  1  one-cycle pulse that starts a frame
beat_total  input  CNT_W  number of 64-bit beats in the frame; sampled on frame_start
m_data  output  128  packed word
m_valid  output  1  m_data valid
m_ready  input  1  downstream accept
m_last  output  1  qualifies the final word of a frame
overflow  output  1  sticky: a word was dropped because the FIFO was full
busy  output  1  frame in progress or FIFO not empty

Behaviour:
- Reset (async, s_rst_n=0): state IDLE. Beat counter, half register and half flag are 0. FIFO is empty. m_valid=0, m_last=0, overflow=0, busy=0. m_data=0.
- Byte order: beat byte = {ch7..ch0}, with ch0 at bits [7:0]. The first beat of a pair goes to m_data[63:0]; the second goes to [127:64].
- FSM states:
  - IDLE: data_in_vld is ignored.
  - ACTIVE: entered on frame_start when beat_total != 0. frame_start with beat_total=0 stays IDLE and generates no word.
- On frame_start:
  - beat_total is latched; the counter, half flag and overflow are cleared.
  - If data_in_vld is high in the same cycle, that beat counts as beat 1 of the new frame.
  - frame_start during ACTIVE aborts the old frame. Any unpaired half beat is discarded. Words already in the FIFO are kept and drained normally; none of them gets m_last from the aborted frame.
- In ACTIVE, each data_in_vld increments the counter:
  - Odd beat: stored in the half register.
  - Even beat: forms a word with the stored half and writes it to the FIFO in the same cycle.
- Final beat (counter reaches beat_total):
  - The word is written with a last tag, and the FSM returns to IDLE on the next edge.
  - If beat_total is odd, the final word is {64'h0, final beat}.
- Latency: the write happens at the edge ending cycle N (the pairing beat). m_valid is high in cycle N+1 if the FIFO was empty. Data/last are registered show-ahead: m_data and m_last are valid whenever m_valid=1.
- Handshake:
  - A transfer occurs on m_valid & m_ready.
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
- FIFO full:
  - A write with no read in the same cycle drops the incoming word and sets overflow (sticky until frame_start or reset).
  - A write and a read in the same cycle while full succeed, and the occupancy stays DEPTH.
- Empty with simultaneous write and read: no read occurs (m_valid is still 0); the write lands normally.
- Pointers wrap modulo DEPTH. Full/empty are derived from an extra pointer MSB.
- busy = (state==ACTIVE) | FIFO not empty.

Test Plan:
- Reset, then frame_start with beat_total=4, then 4 consecutive beats of bytes 0x01..0x08, 0x11..0x18, 0x21..0x28, 0x31..0x38, with m_ready=1 -> 2 words. Word 0 = 128'h1817..11_0807..01. m_last=1 only on word 1. First m_valid occurs the cycle after beat 2.
- beat_total=3 -> 2 words; word 1 upper 64 bits = 0, m_last=1. busy drops after word 1 transfers.
- m_ready=0, DEPTH=16, beat_total=40 -> 16 words held, overflow=1 after the 17th pairing beat. Then m_ready=1 -> exactly 16 words out, words 0..15 intact, no m_last seen.
- FIFO full with m_ready=1 in the cycle a pairing beat arrives -> no drop, overflow stays 0, and the order is preserved.
- Abort: beat_total=6, 3 beats, then frame_start with beat_total=2 plus 2 beats -> output is old word 0 (no last), then the new word with m_last=1. The orphan third beat never appears.
- s_rst_n low mid-frame with a non-empty FIFO -> m_valid, overflow and busy go to 0 immediately (asynchronously). A subsequent frame behaves as in scenario 1.

Source files
------------

// File: rtl/quant_out_pack.sv
// Packs pairs of 64-bit int8 beats from the requantiser into 128-bit words and
// buffers them in a show-ahead FIFO feeding the DDR writer stream.
module quant_out_pack #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic [7:0]       ch0_data_in,
    input  logic [7:0]       ch1_data_in,
    input  logic [7:0]       ch2_data_in,
    input  logic [7:0]       ch3_data_in,
    input  logic [7:0]       ch4_data_in,
    input  logic [7:0]       ch5_data_in,
    input  logic [7:0]       ch6_data_in,
    input  logic [7:0]       ch7_data_in,
    input  logic             data_in_vld,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] beat_total,
    output logic [127:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             overflow,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic         last;
        logic [127:0] data;
    } word_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, total;
    logic [63:0]      half;
    logic             half_vld;

    logic [63:0]      beat;
    logic [CNT_W-1:0] cur_cnt, cur_total, cnt_nxt;
    logic             cur_half, take, final_beat, wr;
    word_t            wr_word;

    word_t            mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, rd, wr_ok, drop;
    word_t            head;

    assign beat = {ch7_data_in, ch6_data_in, ch5_data_in, ch4_data_in,
                   ch3_data_in, ch2_data_in, ch1_data_in, ch0_data_in};

    // A frame_start beat is treated as beat 1 of the new frame, so the
    // working count/half/total are taken from the restart values that cycle.
    always_comb begin
        cur_cnt    = frame_start ? '0 : cnt;
        cur_half   = frame_start ? 1'b0 : half_vld;
        cur_total  = frame_start ? beat_total : total;
        take       = data_in_vld & (frame_start ? (beat_total != '0) : (state == ACTIVE));
        cnt_nxt    = cur_cnt + CNT_W'(1);
        final_beat = take & (cnt_nxt == cur_total);
        wr         = take & (cur_half | final_beat);
        wr_word.last = final_beat;
        wr_word.data = cur_half ? {beat, half} : {64'h0, beat};
    end

    always_comb begin
        state_nxt = state;
        if (frame_start)
            state_nxt = (beat_total != '0) ? ACTIVE : IDLE;
        if (final_beat)
            state_nxt = IDLE;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt      <= '0;
            total    <= '0;
            half     <= '0;
            half_vld <= 1'b0;
        end else begin
            if (frame_start)
                total <= beat_total;
            if (frame_start || take) begin
                cnt      <= take ? cnt_nxt : '0;
                half_vld <= take & ~cur_half & ~final_beat;
            end
            if (take && !cur_half)
                half <= beat;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign rd    = ~empty & m_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok = wr & (~full | rd);
    assign drop  = wr & full & ~rd;

    always_ff @(posedge sclk) begin
        if (wr_ok)
            mem[wr_ptr[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (frame_start)
                overflow <= 1'b0;
        end
    end

    // Outputs are forced to zero while empty so reset and idle look clean.
    assign head    = mem[rd_ptr[AW-1:0]];
    assign m_valid = ~empty;
    assign m_data  = m_valid ? head.data : '0;
    assign m_last  = m_valid & head.last;
    assign busy    = (state == ACTIVE) | ~empty;

endmodule
